// File: rtl/cb_pkg.sv
// Core-bus channel types shared by the read arbiter and its neighbours.
package cb_pkg;

  localparam logic [1:0] CB_OKAY   = 2'b00;
  localparam logic [1:0] CB_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_valid;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic [1:0]  wr_resp;
    logic        wr_resp_valid;
  } s_cb_miso_t;

endpackage

// File: rtl/cb_rd_arbiter.sv
// Shares one core-bus master between fetch (reads only) and LSU, routing read data by issue order.
// Define CB_ARB_RR_EN for round-robin tie breaking instead of fixed DATA_PRIO priority.
module cb_rd_arbiter
  import cb_pkg::*;
#(
  parameter int unsigned MAX_OT    = 4,
  parameter bit          DATA_PRIO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  s_cb_mosi_t               instr_cb_mosi_i,
  output s_cb_miso_t               instr_cb_miso_o,
  input  s_cb_mosi_t               data_cb_mosi_i,
  output s_cb_miso_t               data_cb_miso_o,
  output s_cb_mosi_t               cb_mosi_o,
  input  s_cb_miso_t               cb_miso_i,
  output logic [$clog2(MAX_OT):0]  ot_cnt_o,
  output logic                     rsp_err_o
);

  localparam int unsigned AW = $clog2(MAX_OT);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]     ot_cnt_q, ot_cnt_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [MAX_OT-1:0] order_q;           // requester id per outstanding read, 1 = data
  logic              grant_q, grant;
  logic              lock_q, lock_d;
  logic              ot_full, fifo_empty, head;
  logic              tie_pick, fwd_valid, addr_hs, rsp_ready, pop;
  logic              instr_v, data_v;

  assign instr_v    = instr_cb_mosi_i.rd_addr_valid;
  assign data_v     = data_cb_mosi_i.rd_addr_valid;
  assign ot_full    = (ot_cnt_q == CW'(MAX_OT));
  assign fifo_empty = (ot_cnt_q == '0);
  assign head       = order_q[rd_ptr_q];

`ifdef CB_ARB_RR_EN
  logic rr_q;  // requester that wins the next tie
  assign tie_pick = rr_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b0;
    end else if (addr_hs) begin
      rr_q <= ~grant;
    end
  end
`else
  assign tie_pick = DATA_PRIO;
`endif

  always_comb begin
    grant = grant_q;
    if (lock_q && (grant_q ? data_v : instr_v)) begin
      grant = grant_q;
    end else if (instr_v && data_v) begin
      grant = tie_pick;
    end else if (instr_v) begin
      grant = 1'b0;
    end else if (data_v) begin
      grant = 1'b1;
    end
  end

  assign fwd_valid = (grant ? data_v : instr_v) & ~ot_full;
  assign addr_hs   = fwd_valid & cb_miso_i.rd_addr_ready;
  // With nothing outstanding, stray responses are accepted and dropped.
  assign rsp_ready = fifo_empty ? 1'b1
                   : (head ? data_cb_mosi_i.rd_ready : instr_cb_mosi_i.rd_ready);
  assign pop       = cb_miso_i.rd_valid & rsp_ready & ~fifo_empty;
  assign ot_cnt_d  = ot_cnt_q + CW'(addr_hs) - CW'(pop);
  assign lock_d    = ot_full ? lock_q : (fwd_valid & ~cb_miso_i.rd_addr_ready);
  assign ot_cnt_o  = ot_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ot_cnt_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      order_q  <= '0;
      grant_q  <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      ot_cnt_q <= ot_cnt_d;
      lock_q   <= lock_d;
      if (!ot_full) begin
        grant_q <= grant;
      end
      if (addr_hs) begin
        order_q[wr_ptr_q] <= grant;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, not just after the next edge.
  always_comb begin
    cb_mosi_o       = '0;
    instr_cb_miso_o = '0;
    data_cb_miso_o  = '0;
    rsp_err_o       = 1'b0;
    if (rst) begin
      cb_mosi_o.rd_addr       = grant ? data_cb_mosi_i.rd_addr : instr_cb_mosi_i.rd_addr;
      cb_mosi_o.rd_size       = grant ? data_cb_mosi_i.rd_size : instr_cb_mosi_i.rd_size;
      cb_mosi_o.rd_addr_valid = fwd_valid;
      cb_mosi_o.rd_ready      = rsp_ready;
      cb_mosi_o.wr_addr       = data_cb_mosi_i.wr_addr;
      cb_mosi_o.wr_size       = data_cb_mosi_i.wr_size;
      cb_mosi_o.wr_addr_valid = data_cb_mosi_i.wr_addr_valid;
      cb_mosi_o.wr_data       = data_cb_mosi_i.wr_data;
      cb_mosi_o.wr_strb       = data_cb_mosi_i.wr_strb;
      cb_mosi_o.wr_data_valid = data_cb_mosi_i.wr_data_valid;
      cb_mosi_o.wr_resp_ready = data_cb_mosi_i.wr_resp_ready;

      instr_cb_miso_o.rd_addr_ready = ~grant & cb_miso_i.rd_addr_ready & ~ot_full;
      instr_cb_miso_o.rd_data       = cb_miso_i.rd_data;
      instr_cb_miso_o.rd_resp       = cb_miso_i.rd_resp;
      instr_cb_miso_o.rd_valid      = cb_miso_i.rd_valid & ~fifo_empty & ~head;

      data_cb_miso_o.rd_addr_ready  = grant & cb_miso_i.rd_addr_ready & ~ot_full;
      data_cb_miso_o.rd_data        = cb_miso_i.rd_data;
      data_cb_miso_o.rd_resp        = cb_miso_i.rd_resp;
      data_cb_miso_o.rd_valid       = cb_miso_i.rd_valid & ~fifo_empty & head;
      data_cb_miso_o.wr_addr_ready  = cb_miso_i.wr_addr_ready;
      data_cb_miso_o.wr_data_ready  = cb_miso_i.wr_data_ready;
      data_cb_miso_o.wr_resp        = cb_miso_i.wr_resp;
      data_cb_miso_o.wr_resp_valid  = cb_miso_i.wr_resp_valid;

      rsp_err_o = cb_miso_i.rd_valid & fifo_empty;
    end
  end

  logic unused_instr_wr;
  assign unused_instr_wr = ^{instr_cb_mosi_i.wr_addr, instr_cb_mosi_i.wr_size,
                             instr_cb_mosi_i.wr_addr_valid, instr_cb_mosi_i.wr_data,
                             instr_cb_mosi_i.wr_strb, instr_cb_mosi_i.wr_data_valid,
                             instr_cb_mosi_i.wr_resp_ready};

endmodule
